// File: rtl/tft_pkg.sv
// Shared TFT panel definitions: panel geometry, ILI9341 command codes used by
// the game, decoder FSM encoding and a coordinate clamp helper.
package tft_pkg;

  localparam int TFT_WIDTH  = 240;
  localparam int TFT_HEIGHT = 320;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_PASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_SKIP  = 3'd4
  } dec_state_t;

  // Clamp a 16-bit window parameter to the last valid coordinate below lim.
  function automatic logic [8:0] sat_coord(input logic [15:0] v, input logic [15:0] lim);
    logic [15:0] top;
    top = lim - 16'd1;
    return (v >= lim) ? top[8:0] : v[8:0];
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronises the raw pins, finds SCLK
// rising edges and assembles MSB-first bytes while CS is low.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc
);

  logic [1:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [1:0] dc_sync_q, dc_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic       sclk_prev_q, sclk_prev_d;
  logic       rise_q, rise_d;
  logic       mosi_smp_q, mosi_smp_d;
  logic       dc_smp_q, dc_smp_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_dc_q, byte_dc_d;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[0], spi_clk};
    mosi_sync_d  = {mosi_sync_q[0], spi_mosi};
    dc_sync_d    = {dc_sync_q[0], spi_dc};
    cs_sync_d    = {cs_sync_q[0], spi_cs};
    sclk_prev_d  = sclk_sync_q[1];
    // Edge flag and data samples are registered together so the shift stage
    // sees MOSI/DC as they were when the edge was detected.
    rise_d       = sclk_sync_q[1] & ~sclk_prev_q;
    mosi_smp_d   = mosi_sync_q[1];
    dc_smp_d     = dc_sync_q[1];
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_dc_d    = byte_dc_q;
    if (cs_sync_q[1]) begin
      cnt_d   = 3'd0;
      shift_d = 7'd0;
    end else if (rise_q) begin
      shift_d = {shift_q[5:0], mosi_smp_q};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = {shift_q, mosi_smp_q};
        byte_dc_d    = dc_smp_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q  <= 2'b00;
      mosi_sync_q  <= 2'b00;
      dc_sync_q    <= 2'b00;
      cs_sync_q    <= 2'b11;
      sclk_prev_q  <= 1'b0;
      rise_q       <= 1'b0;
      mosi_smp_q   <= 1'b0;
      dc_smp_q     <= 1'b0;
      cnt_q        <= 3'd0;
      shift_q      <= 7'd0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'd0;
      byte_dc_q    <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      dc_sync_q    <= dc_sync_d;
      cs_sync_q    <= cs_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      rise_q       <= rise_d;
      mosi_smp_q   <= mosi_smp_d;
      dc_smp_q     <= dc_smp_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_dc_q    <= byte_dc_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_dc    = byte_dc_q;

endmodule

// File: rtl/tft_spi_decoder.sv
// TFT SPI stream decoder: turns CASET/PASET/RAMWR traffic into per-pixel
// strobes with screen coordinate and RGB565 colour.
module tft_spi_decoder
  import tft_pkg::*;
#(
  parameter int WIDTH  = TFT_WIDTH,
  parameter int HEIGHT = TFT_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  input  logic        spi_dc,
  input  logic        spi_cs,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        range_err
);

  localparam logic [15:0] W_LIM = 16'(WIDTH);
  localparam logic [15:0] H_LIM = 16'(HEIGHT);
  localparam logic [8:0]  X_MAX = 9'(WIDTH - 1);
  localparam logic [8:0]  Y_MAX = 9'(HEIGHT - 1);

  logic       rx_valid, rx_dc;
  logic [7:0] rx_data;

  spi_byte_rx u_rx (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .byte_dc    (rx_dc)
  );

  dec_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] start_q, start_d;
  logic [7:0]  end_hi_q, end_hi_d;
  logic [7:0]  hi_q, hi_d;
  logic        phase_q, phase_d;
  logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic        x_ok_q, x_ok_d, y_ok_q, y_ok_d;
  logic [8:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_color_q, pix_color_d;
  logic        range_err_q, range_err_d;
  logic [15:0] lim, end_val;
  logic [8:0]  s_sat, e_sat;
  logic        oob;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_d     = start_q;
    end_hi_d    = end_hi_q;
    hi_d        = hi_q;
    phase_d     = phase_q;
    xs_d        = xs_q;
    xe_d        = xe_q;
    ys_d        = ys_q;
    ye_d        = ye_q;
    x_ok_d      = x_ok_q;
    y_ok_d      = y_ok_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    range_err_d = range_err_q;
    lim         = (state_q == ST_CASET) ? W_LIM : H_LIM;
    end_val     = {end_hi_q, rx_data};
    s_sat       = sat_coord(start_q, lim);
    e_sat       = sat_coord(end_val, lim);
    oob         = (start_q >= lim) || (end_val >= lim);
    if (rx_valid) begin
      if (!rx_dc) begin
        // Commands always win, even mid-parameter or between colour bytes.
        idx_d   = 2'd0;
        phase_d = 1'b0;
        case (rx_data)
          CMD_CASET: state_d = ST_CASET;
          CMD_PASET: state_d = ST_PASET;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            cur_x_d = xs_q;
            cur_y_d = ys_q;
          end
          default:   state_d = ST_SKIP;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
              2'd0:    start_d[15:8] = rx_data;
              2'd1:    start_d[7:0]  = rx_data;
              2'd2:    end_hi_d      = rx_data;
              default: begin
                state_d = ST_IDLE;
                if (oob || (s_sat > e_sat)) range_err_d = 1'b1;
                if (state_q == ST_CASET) begin
                  xs_d   = s_sat;
                  xe_d   = e_sat;
                  x_ok_d = (s_sat <= e_sat);
                end else begin
                  ys_d   = s_sat;
                  ye_d   = e_sat;
                  y_ok_d = (s_sat <= e_sat);
                end
              end
            endcase
          end
          ST_RAMWR: begin
            if (!phase_q) begin
              hi_d    = rx_data;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (x_ok_q && y_ok_q) begin
                pix_valid_d = 1'b1;
                pix_x_d     = cur_x_q;
                pix_y_d     = cur_y_q;
                pix_color_d = {hi_q, rx_data};
                if (cur_x_q == xe_q) begin
                  cur_x_d = xs_q;
                  cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 9'd1;
                end else begin
                  cur_x_d = cur_x_q + 9'd1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      start_q     <= 16'd0;
      end_hi_q    <= 8'd0;
      hi_q        <= 8'd0;
      phase_q     <= 1'b0;
      xs_q        <= 9'd0;
      xe_q        <= X_MAX;
      ys_q        <= 9'd0;
      ye_q        <= Y_MAX;
      x_ok_q      <= 1'b1;
      y_ok_q      <= 1'b1;
      cur_x_q     <= 9'd0;
      cur_y_q     <= 9'd0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= 9'd0;
      pix_y_q     <= 9'd0;
      pix_color_q <= 16'd0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      end_hi_q    <= end_hi_d;
      hi_q        <= hi_d;
      phase_q     <= phase_d;
      xs_q        <= xs_d;
      xe_q        <= xe_d;
      ys_q        <= ys_d;
      ye_q        <= ye_d;
      x_ok_q      <= x_ok_d;
      y_ok_q      <= y_ok_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      range_err_q <= range_err_d;
    end
  end

  assign byte_valid = rx_valid;
  assign byte_data  = rx_data;
  assign byte_dc    = rx_dc;
  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign range_err  = range_err_q;

endmodule

// File: tb/tb_tft_spi_decoder.sv
// Directed bench for tft_spi_decoder: bit-bangs SPI traffic and scoreboards
// the pixel strobes against an expected queue.
module tb_tft_spi_decoder;

  logic        clk;
  logic        rst;
  logic        spi_clk, spi_mosi, spi_dc, spi_cs;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        pix_valid;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_color;
  logic        range_err;

  int total = 0;
  int bad   = 0;
  int byte_cnt = 0;
  logic [3:0]  bv_trace;
  logic [33:0] exp_q[$];

  tft_spi_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .spi_cs     (spi_cs),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .range_err  (range_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pixel strobes popped against the expected queue
  always @(negedge clk) begin
    if (rst && byte_valid) byte_cnt++;
    if (rst && pix_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL pix_spurious observed=(%0d,%0d,%0h) expected=none", pix_x, pix_y, pix_color);
      end
      if (exp_q.size() != 0) check("pix", {30'd0, pix_x, pix_y, pix_color}, {30'd0, exp_q.pop_front()});
    end
  end

  task automatic push_pix(input int x, input int y, input logic [15:0] c);
    exp_q.push_back({9'(x), 9'(y), c});
  endtask

  // Drivers
  task automatic send_bits(input logic dc, input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = data[7-i];
      spi_dc   = dc;
      repeat (4) @(negedge clk);
      spi_clk = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        bv_trace[j] = byte_valid;
      end
      spi_clk = 1'b0;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] data);
    send_bits(dc, data, 8);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(1'b0, c);
  endtask

  task automatic send_dat(input logic [7:0] d);
    send_byte(1'b1, d);
  endtask

  task automatic send_pix(input logic [15:0] c);
    send_dat(c[15:8]);
    send_dat(c[7:0]);
  endtask

  task automatic set_win(input logic [7:0] cmd, input logic [15:0] s, input logic [15:0] e);
    send_cmd(cmd);
    send_dat(s[15:8]);
    send_dat(s[7:0]);
    send_dat(e[15:8]);
    send_dat(e[7:0]);
  endtask

  initial begin
    int cnt0;
    rst = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0; spi_cs = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_byte_valid", {63'd0, byte_valid}, 64'd0);
    check("rst_byte_data", {56'd0, byte_data}, 64'd0);
    check("rst_pix_valid", {63'd0, pix_valid}, 64'd0);
    check("rst_pix_xy", {46'd0, pix_x, pix_y}, 64'd0);
    check("rst_range_err", {63'd0, range_err}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with exact latency
    send_cmd(8'hA5);
    check("single_latency", {60'd0, bv_trace}, 64'h8);
    check("single_data", {56'd0, byte_data}, 64'hA5);
    check("single_dc", {63'd0, byte_dc}, 64'd0);
    check("single_count", 64'(byte_cnt), 64'd1);

    // 2x2 window with wrap
    set_win(8'h2A, 16'd10, 16'd11);
    check("caset_dc", {63'd0, byte_dc}, 64'd1);
    set_win(8'h2B, 16'd20, 16'd21);
    send_cmd(8'h2C);
    push_pix(10, 20, 16'hF800); send_pix(16'hF800);
    check("pix0_color_held", {48'd0, pix_color}, 64'hF800);
    push_pix(11, 20, 16'h07E0); send_pix(16'h07E0);
    push_pix(10, 21, 16'h001F); send_pix(16'h001F);
    push_pix(11, 21, 16'hFFFF); send_pix(16'hFFFF);
    push_pix(10, 20, 16'h1234); send_pix(16'h1234);
    check("win_range_err", {63'd0, range_err}, 64'd0);

    // Abort mid-byte with CS
    cnt0 = byte_cnt;
    send_bits(1'b0, 8'hFF, 5);
    spi_cs = 1'b1;
    repeat (8) @(negedge clk);
    spi_cs = 1'b0;
    repeat (6) @(negedge clk);
    send_cmd(8'h2C);
    check("abort_count", 64'(byte_cnt - cnt0), 64'd1);
    check("abort_data", {56'd0, byte_data}, 64'h2C);

    // Command between high and low colour bytes
    send_dat(8'h12);
    send_cmd(8'h00);
    send_cmd(8'h2C);
    push_pix(10, 20, 16'h3456);
    send_dat(8'h34);
    send_dat(8'h56);
    check("intr_queue_empty", 64'(exp_q.size()), 64'd0);

    // Out-of-range end column saturates to WIDTH-1
    set_win(8'h2A, 16'd238, 16'd300);
    check("oor_range_err", {63'd0, range_err}, 64'd1);
    set_win(8'h2B, 16'd5, 16'd5);
    send_cmd(8'h2C);
    push_pix(238, 5, 16'hAAAA); send_pix(16'hAAAA);
    push_pix(239, 5, 16'hBBBB); send_pix(16'hBBBB);
    push_pix(238, 5, 16'hCCCC); send_pix(16'hCCCC);

    // Reset mid-frame
    send_cmd(8'h2C);
    send_dat(8'h99);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mrst_pix_xy", {46'd0, pix_x, pix_y}, 64'd0);
    check("mrst_pix_color", {48'd0, pix_color}, 64'd0);
    check("mrst_byte_data", {56'd0, byte_data}, 64'd0);
    check("mrst_range_err", {63'd0, range_err}, 64'd0);
    repeat (6) @(negedge clk);
    send_cmd(8'h2C);
    push_pix(0, 0, 16'hABCD); send_pix(16'hABCD);
    push_pix(1, 0, 16'h5A5A); send_pix(16'h5A5A);

    // Inverted row window: flagged and no pixels produced
    set_win(8'h2B, 16'd9, 16'd3);
    check("inv_range_err", {63'd0, range_err}, 64'd1);
    send_cmd(8'h2C);
    send_pix(16'h1111);
    send_pix(16'h2222);
    repeat (10) @(negedge clk);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tft_spi_decoder.md
# tft_spi_decoder

Display-side receiver for the TFT SPI stream that the game drives onto the tft_*/analyzer_* pins. It oversamples SCLK/MOSI/DC/CS in the system clock domain, assembles bytes, and decodes the ILI9341-style command subset the game uses: CASET (0x2A), PASET (0x2B) and RAMWR (0x2C). It emits one strobe per written pixel with its screen coordinate and RGB565 colour. It serves as the on-chip checker and frame-model feeder for the transmitter, initialiser, scene and player drawers.

## Interface
- WIDTH, 240: panel columns; x range 0..WIDTH-1.
- HEIGHT, 320: panel rows; y range 0..HEIGHT-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- spi_clk  in  1  raw SCLK, asynchronous to clk.
- spi_mosi  in  1  raw MOSI, MSB first.
- spi_dc  in  1  raw D/C; 0 = command, 1 = data.
- spi_cs  in  1  raw chip select, active-low.
- byte_valid  out  1  one-cycle strobe: a complete byte was received.
- byte_data  out  8  received byte; held until the next byte.
- byte_dc  out  1  DC level latched with bit 0 of that byte.
- pix_valid  out  1  one-cycle strobe: a pixel was written.
- pix_x  out  9  column of the written pixel.
- pix_y  out  9  row of the written pixel.
- pix_color  out  16  RGB565 value, high byte first on the wire.
- range_err  out  1  sticky flag: an out-of-range or inverted window was received; cleared only by reset.

## Operation
- **Input synchronisation.** A 2-FF synchroniser on each of spi_clk, spi_mosi, spi_dc and spi_cs. A rising edge is detected on the synchronised SCLK. SPI mode 0: MOSI and DC are sampled on the SCLK rising edge.
- **Bit counter (3 bits).** Counts only while synchronised CS = 0. Synchronised CS = 1 resets the counter to 0 and drops any partial byte. The command-FSM state and the window registers are kept across CS high.
- **Byte completion.** On the 8th sampled bit:
  - byte_valid pulses;
  - byte_data takes the shift register contents;
  - byte_dc takes the DC level sampled with that bit;
  - the counter wraps to 0.
- **Command FSM.** States: IDLE, CASET, PASET, RAMWR, SKIP.
  - Any byte with DC = 0 is a command and overrides the current state, including one mid-sequence.
  - 0x2A goes to CASET and 0x2B goes to PASET, each with the parameter index cleared to 0.
  - 0x2C goes to RAMWR: cursor := (xs, ys), high/low-byte phase := high.
  - Any other command goes to SKIP. DC = 1 bytes in SKIP or IDLE are ignored.
- **CASET/PASET parameters.** Four DC = 1 bytes, in the order start hi, start lo, end hi, end lo, forming 16-bit values.
  - After the 4th byte, commit the start and end to (xs, xe) for CASET or (ys, ye) for PASET, then return to IDLE.
  - A value ≥ WIDTH (for x) or ≥ HEIGHT (for y) saturates to WIDTH-1 or HEIGHT-1 and sets range_err.
  - start > end after saturation: commit the values anyway, set range_err, and mark the window invalid.
- **RAMWR.** DC = 1 bytes alternate high byte, low byte. On the low byte:
  - pix_valid pulses with pix_x/pix_y = cursor and pix_color = {hi, lo}.
  - Cursor advance: if x == xe then x := xs, y := (y == ye) ? ys : y+1; otherwise x := x+1.
  - Invalid window: bytes are consumed but no pix_valid is produced.
  - A command arriving between the high and low byte discards the high byte.
- **Reset values.** All outputs 0. xs = 0, xe = WIDTH-1, ys = 0, ye = HEIGHT-1. State IDLE. Bit counter 0.

## Timing
- Required input timing: SCLK high and SCLK low each ≥ 3 clk periods. MOSI and DC stable from ≥ 3 clk before to ≥ 3 clk after each SCLK rising edge.
- byte_valid asserts exactly 3 clk after the first clk edge that registers spi_clk high on the 8th bit: 2 cycles of synchroniser plus 1 cycle of edge and shift.
- pix_valid asserts 1 clk after the byte_valid of the low byte. pix_x, pix_y and pix_color are valid in that same cycle and held until the next pixel.
- Window registers update in the cycle after the byte_valid of the 4th parameter, so a RAMWR that follows immediately uses the new window.
- Mid-operation reset: all state returns to reset values on the next clk edge. Bytes in flight are lost.
- Throughput: at most one byte per 6 clk. The FSM never stalls, and there is no backpressure.

## Structure
- Shared package tft_pkg:
  - command codes CMD_CASET = 8'h2A, CMD_PASET = 8'h2B, CMD_RAMWR = 8'h2C;
  - the FSM state encoding;
  - panel size constants, also used by player and scene_exhibitor.
- Sub-module spi_byte_rx: synchronisers, edge detection, bit counter and shift register. It outputs byte_valid, byte_data and byte_dc.
- The command FSM and cursor logic live in the top of tft_spi_decoder.

## Test plan
- **Single byte.** Bit-bang command 0xA5 with DC = 0 and SCLK half-period 4 clk → one byte_valid with byte_data = 0xA5, byte_dc = 0, exactly 3 clk after the 8th SCLK rising edge.
- **2×2 window.** CASET 0,10,0,11; PASET 0,20,0,21; RAMWR then 4 pixels 0xF800, 0x07E0, 0x001F, 0xFFFF → pix_valid at (10,20), (11,20), (10,21), (11,21) with those colours. A 5th pixel wraps to (10,20).
- **Abort mid-byte.** Drive CS high after 5 bits, then send 0x2C → no spurious byte; exactly one byte_valid with data 0x2C.
- **Out-of-range window.** CASET 0,0,1,0x2C (300) → xe = 239 and range_err = 1. PASET end < start → range_err = 1, and RAMWR data produces no pix_valid.
- **Command interrupts a pixel.** RAMWR, high byte 0x12, then command 0x00, then RAMWR, 0x34, 0x56 → single pixel 0x3456 at (xs, ys).
- **Reset mid-frame.** rst low for 1 clk during RAMWR → outputs 0 and window reset to full screen. The next RAMWR pixel lands at (0,0).
